// File: rtl/spart_bus_ctrl.sv
// rtl/spart_bus_ctrl.sv - SPART bus controller: register decode, baud divisor, RX FIFO, TX handshake.
// Optional macro RX_OVERRUN_EN adds a sticky RX overrun flag on status bit 2.
module spart_bus_ctrl #(
  parameter int          RX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'h28B1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs,
  input  logic        iorw,
  input  logic [1:0]  ioaddr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        rda,
  output logic        tbr,
  output logic [15:0] divisor_buffer,
  input  logic        rx_done,
  input  logic [9:0]  rx_shift_reg,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT, TX_DRAIN} tx_state_t;

  logic          rd_cyc, wr_cyc;
  logic          pop, push, full;
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          ovr;
  logic [7:0]    hold_data;
  logic          hold_full;
  tx_state_t     state, state_next;
  logic          load_tx, clr_hold;
  logic          unused_frame_bits;

  // Start and stop bits of the received frame are never stored.
  assign unused_frame_bits = rx_shift_reg[9] ^ rx_shift_reg[0];

  assign rd_cyc = iocs & iorw;
  assign wr_cyc = iocs & ~iorw;
  assign full   = (count == CW'(RX_DEPTH));
  assign pop    = rd_cyc && (ioaddr == 2'b00) && (count != '0);
  assign push   = rx_done && (!full || pop);
  assign tbr    = ~hold_full;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rda    <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rx_shift_reg[8:1];
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      rda   <= (count_next != '0);
    end
  end

`ifdef RX_OVERRUN_EN
  // Set has priority over the clear from a status read.
  always_ff @(posedge clk) begin
    if (rst)
      ovr <= 1'b0;
    else if (rx_done && full && !pop)
      ovr <= 1'b1;
    else if (rd_cyc && (ioaddr == 2'b01))
      ovr <= 1'b0;
  end
`else
  assign ovr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata <= 8'h00;
    end else if (rd_cyc) begin
      case (ioaddr)
        2'b00:   bus_rdata <= pop ? fifo_mem[rd_ptr] : 8'h00;
        2'b01:   bus_rdata <= {5'b0, ovr, tbr, rda};
        2'b10:   bus_rdata <= divisor_buffer[7:0];
        default: bus_rdata <= divisor_buffer[15:8];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_buffer <= DEFAULT_DIV;
    end else if (wr_cyc) begin
      if (ioaddr == 2'b10) divisor_buffer[7:0]  <= bus_wdata;
      if (ioaddr == 2'b11) divisor_buffer[15:8] <= bus_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    clr_hold   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (hold_full && !tx_busy) begin
          load_tx    = 1'b1;
          state_next = TX_START;
        end
      end
      TX_START: begin
        clr_hold   = 1'b1;
        state_next = TX_WAIT;
      end
      TX_WAIT:  if (tx_busy)  state_next = TX_DRAIN;
      TX_DRAIN: if (!tx_busy) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // tx_start is registered so it is high exactly while the FSM sits in TX_START.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else begin
      tx_start <= load_tx;
      if (load_tx)
        tx_data <= hold_data;
      if (clr_hold) begin
        hold_full <= 1'b0;
      end else if (wr_cyc && (ioaddr == 2'b00) && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= bus_wdata;
      end
    end
  end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb/tb_spart_bus_ctrl.sv - directed self-checking bench for spart_bus_ctrl.
module tb_spart_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        iocs, iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        rda, tbr, rx_done, tx_start, tx_busy;
  logic [15:0] divisor_buffer;
  logic [9:0]  rx_shift_reg;
  logic [7:0]  tx_data;
  logic [7:0]  rd;
  logic [7:0]  ovr_status;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  spart_bus_ctrl dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .rda(rda), .tbr(tbr),
    .divisor_buffer(divisor_buffer), .rx_done(rx_done), .rx_shift_reg(rx_shift_reg),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; bus_wdata = d;
    tick();
    iocs = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    tick();
    iocs = 1'b0;
    d = bus_rdata;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_shift_reg = {1'b1, b, 1'b0};
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  initial begin
`ifdef RX_OVERRUN_EN
    ovr_status = 8'h06;
`else
    ovr_status = 8'h02;
`endif
    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; bus_wdata = 8'h00;
    rx_done = 1'b0; rx_shift_reg = 10'h000; tx_busy = 1'b0;
    tick(); tick();
    chk("reset_div", divisor_buffer, 16'h28B1);
    chk("reset_rdata", bus_rdata, 8'h00);
    chk("reset_tbr_rda", {tbr, rda}, 2'b10);
    chk("reset_tx", {tx_start, tx_data}, 9'h000);
    rst = 1'b0;

    bus_read(2'b01, rd); chk("status_idle", rd, 8'h02);
    bus_read(2'b10, rd); chk("div_lo", rd, 8'hB1);
    bus_read(2'b11, rd); chk("div_hi", rd, 8'h28);
    chk("no_tx_start", tx_start, 1'b0);

    bus_write(2'b10, 8'h44); chk("div_after_lo", divisor_buffer, 16'h2844);
    bus_write(2'b11, 8'h01); chk("div_after_hi", divisor_buffer, 16'h0144);

    rx_shift_reg = 10'b1_1010_0101_0; rx_done = 1'b1; tick(); rx_done = 1'b0;
    chk("rda_after_push", rda, 1'b1);
    bus_read(2'b00, rd); chk("rx_a5", rd, 8'hA5);
    chk("rda_after_pop", rda, 1'b0);

    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    for (int i = 1; i <= 4; i++) begin
      bus_read(2'b00, rd); chk($sformatf("overflow_rd%0d", i), rd, 32'(i));
    end
    bus_read(2'b00, rd); chk("empty_rd", rd, 8'h00);
    bus_read(2'b01, rd); chk("status_ovr", rd, ovr_status);
    bus_read(2'b01, rd); chk("status_ovr_clr", rd, 8'h02);

    bus_write(2'b00, 8'h5A);
    chk("tbr_after_wr", {tbr, tx_start}, 2'b00);
    tick(); chk("tx_start_5a", {tx_start, tx_data}, {1'b1, 8'h5A});
    chk("tbr_in_start", tbr, 1'b0);
    tick(); chk("tx_start_off", {tx_start, tbr}, 2'b01);
    bus_write(2'b00, 8'h33);
    chk("tbr_preload", tbr, 1'b0);
    tick(); tick(); chk("wait_hold", {tx_start, tbr, tx_data}, {2'b00, 8'h5A});
    tx_busy = 1'b1; tick(); tick();
    bus_write(2'b00, 8'hEE);
    chk("drain_hold", {tx_start, tbr, tx_data}, {2'b00, 8'h5A});
    tx_busy = 1'b0; tick(); chk("drain_exit", tx_start, 1'b0);
    tick(); chk("tx_start_33", {tx_start, tx_data}, {1'b1, 8'h33});
    tick(); chk("tbr_after_33", {tx_start, tbr}, 2'b01);
    tx_busy = 1'b1; tick(); tx_busy = 1'b0; tick(); tick();

    rx_push(8'h10); rx_push(8'h20); rx_push(8'h30); rx_push(8'h40);
    rx_shift_reg = {1'b1, 8'h77, 1'b0}; rx_done = 1'b1;
    bus_read(2'b00, rd); rx_done = 1'b0;
    chk("full_pushpop_head", rd, 8'h10);
    bus_read(2'b00, rd); chk("full_pp_1", rd, 8'h20);
    bus_read(2'b00, rd); chk("full_pp_2", rd, 8'h30);
    bus_read(2'b00, rd); chk("full_pp_3", rd, 8'h40);
    bus_read(2'b00, rd); chk("full_pp_77", rd, 8'h77);
    chk("full_pp_rda", rda, 1'b0);
    bus_read(2'b01, rd); chk("full_pp_no_ovr", rd, 8'h02);

    rx_shift_reg = {1'b1, 8'h99, 1'b0}; rx_done = 1'b1;
    bus_read(2'b00, rd); rx_done = 1'b0;
    chk("empty_pushpop_rd", rd, 8'h00);
    chk("empty_pushpop_rda", rda, 1'b1);
    bus_read(2'b00, rd); chk("empty_pushpop_land", rd, 8'h99);

    rx_push(8'hC3); bus_write(2'b10, 8'h00); bus_write(2'b00, 8'h11);
    rst = 1'b1; tick();
    chk("midreset_state", {rda, tbr, tx_start}, 3'b010);
    chk("midreset_div", divisor_buffer, 16'h28B1);
    rst = 1'b0; tick(); tick();
    chk("midreset_no_start", tx_start, 1'b0);
    bus_read(2'b00, rd); chk("midreset_fifo_empty", rd, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
